// File: rtl/rom_ctrl_hash_sink_if.sv
// ROM word stream from the ROM read counter (master) to the hash sink (slave).
interface rom_ctrl_hash_sink_if #(
  parameter int RomDepth  = 16,
  parameter int DataWidth = 32
) ();
  localparam int AW = $clog2(RomDepth);

  logic                 rom_vld;
  logic                 rom_rdy;
  logic [AW-1:0]        rom_addr;
  logic [DataWidth-1:0] rom_data;
  logic                 rom_last_nontop;

  modport master (output rom_vld, rom_addr, rom_data, rom_last_nontop, input rom_rdy);
  modport slave  (input rom_vld, rom_addr, rom_data, rom_last_nontop, output rom_rdy);
endinterface

// File: rtl/rom_ctrl_hash_sink.sv
// Consumer end of the ROM checker stream: forwards non-top words to KMAC through a
// 2-entry buffer, captures the top words as the expected digest and issues a verdict.
module rom_ctrl_hash_sink #(
  parameter int RomDepth    = 16,
  parameter int RomTopCount = 2,
  parameter int DataWidth   = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  rom_ctrl_hash_sink_if.slave              rom,
  output logic                             kmac_valid_o,
  input  logic                             kmac_ready_i,
  output logic [DataWidth-1:0]             kmac_data_o,
  output logic                             kmac_last_o,
  input  logic                             digest_valid_i,
  input  logic [RomTopCount*DataWidth-1:0] digest_i,
  output logic [RomTopCount*DataWidth-1:0] exp_digest_o,
  output logic                             done_o,
  output logic                             good_o,
  output logic                             error_o
);
  localparam int AW = $clog2(RomDepth);
  localparam logic [AW-1:0] LastNonTopAddr = AW'(RomDepth - RomTopCount - 1);
  localparam logic [AW-1:0] TopBaseAddr    = AW'(RomDepth - RomTopCount);
  localparam logic [AW-1:0] FinalAddr      = AW'(RomDepth - 1);

  typedef enum logic [2:0] {Hash, Top, Wait, Done, Err} state_e;

  state_e                           state_q, state_d;
  logic [AW-1:0]                    exp_q;
  logic [RomTopCount*DataWidth-1:0] exp_digest_q;
  logic                             good_q;

  logic [DataWidth-1:0] fifo_data_q [2];
  logic [1:0]           fifo_last_q;
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           fifo_cnt_q;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic rom_acc, word_bad;

  assign fifo_full  = (fifo_cnt_q == 2'd2);
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign rom_acc    = rom.rom_vld & rom.rom_rdy;
  // A word is bad if out of sequence or if its last-non-top flag disagrees with its address.
  assign word_bad   = (rom.rom_addr != exp_q) |
                      (rom.rom_last_nontop != (rom.rom_addr == LastNonTopAddr));
  assign fifo_push  = rom_acc & (state_q == Hash);
  assign fifo_pop   = kmac_valid_o & kmac_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Hash;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Hash: begin
        if (digest_valid_i || (rom_acc && word_bad)) state_d = Err;
        else if (rom_acc && rom.rom_last_nontop)     state_d = Top;
      end
      Top: begin
        if (digest_valid_i || (rom_acc && word_bad)) state_d = Err;
        else if (rom_acc && exp_q == FinalAddr)      state_d = Wait;
      end
      Wait:    if (digest_valid_i) state_d = Done;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    rom.rom_rdy = 1'b0;
    done_o      = 1'b0;
    good_o      = 1'b0;
    error_o     = 1'b0;
    unique case (state_q)
      Hash: rom.rom_rdy = ~fifo_full;
      Top:  rom.rom_rdy = 1'b1;
      Done: begin
        done_o = 1'b1;
        good_o = good_q;
      end
      Err: begin
        done_o  = 1'b1;
        error_o = 1'b1;
      end
      default: rom.rom_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q        <= '0;
      exp_digest_q <= '0;
      good_q       <= 1'b0;
    end else begin
      if (rom_acc) exp_q <= exp_q + AW'(1);
      if (state_q == Top && rom_acc) begin
        for (int k = 0; k < RomTopCount; k++) begin
          if (exp_q == TopBaseAddr + AW'(k)) exp_digest_q[k*DataWidth +: DataWidth] <= rom.rom_data;
        end
      end
      if (state_q == Wait && digest_valid_i) good_q <= (digest_i == exp_digest_q);
    end
  end

  // Buffer control; the payload array needs no reset because the head is masked when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      if (fifo_push) begin
        fifo_last_q[wr_ptr_q] <= rom.rom_last_nontop;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_data_q[wr_ptr_q] <= rom.rom_data;
  end

  assign kmac_valid_o = ~fifo_empty;
  assign kmac_data_o  = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign kmac_last_o  = ~fifo_empty & fifo_last_q[rd_ptr_q];
  assign exp_digest_o = exp_digest_q;
endmodule
